fft_result_serializer: RTL and testbench

//  Downstream of the radix-2 butterfly: captures each butterfly result (A_re, A_im, B_re, B_im,

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_res_fifo.sv | 74 +++++++
 rtl/fft_result_serializer.sv | 160 ++++++++++++++++
 tb/tb_fft_result_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fft_pkg
// Description : Shared types and constants for the FFT result serializer.
//               fft_result_t packs one butterfly result with A_re in the most
//               significant word, so the frame byte order equals the packed
//               bit order from MSB down.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    typedef struct packed {
        logic [31:0] a_re;
        logic [31:0] a_im;
        logic [31:0] b_re;
        logic [31:0] b_im;
    } fft_result_t;

    localparam int RES_PAYLOAD_BYTES = 16;
    localparam int FRAME_OVERHEAD    = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fft_res_fifo
// Description : Synchronous FIFO of fft_result_t records. A push while full
//               is accepted only when a pop happens in the same cycle. The
//               head record is presented combinationally on pop_data.
// Ports       : i_clk, i_rst       clock, synchronous active-high reset
//               push, push_data    write request and record
//               pop, pop_data      read request and head record
//               full, empty, count occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fft_res_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         push,
    input  fft_result_t                  push_data,
    input  logic                         pop,
    output fft_result_t                  pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fft_result_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset: only entries between the pointers are valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fft_result_serializer
// Description : Captures radix-2 butterfly results (four IEEE-754 singles),
//               buffers up to DEPTH records and streams each one as a byte
//               frame over a valid/ready byte interface, MSB byte of A_re
//               first, then A_im, B_re, B_im.
//               Build option FFT_SER_FRAME_EN: frames become HDR_BYTE,
//               16 payload bytes, XOR checksum (18 bytes). Without it the
//               frame is the 16 payload bytes only and HDR_BYTE does not
//               exist as a parameter.
// Ports       : i_clk, i_rst       clock, synchronous active-high reset
//               i_res_valid        result pulse, i_A_re/i_A_im/i_B_re/i_B_im
//               o_data, o_valid, i_ready, o_last   byte stream
//               o_fill             records held in the FIFO
//               o_overflow         sticky drop flag
//               o_busy             FIFO non-empty or frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fft_result_serializer
    import fft_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef FFT_SER_FRAME_EN
    ,
    parameter logic [7:0] HDR_BYTE = 8'hA5
`endif
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_res_valid,
    input  logic [31:0]                 i_A_re,
    input  logic [31:0]                 i_A_im,
    input  logic [31:0]                 i_B_re,
    input  logic [31:0]                 i_B_im,
    output logic [7:0]                  o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last,
    output logic [$clog2(DEPTH+1)-1:0]  o_fill,
    output logic                        o_overflow,
    output logic                        o_busy
);

`ifdef FFT_SER_FRAME_EN
    localparam logic [4:0] LAST_IDX = 5'(RES_PAYLOAD_BYTES + FRAME_OVERHEAD - 1);
    // Index of the last payload byte within the frame (header is index 0).
    localparam logic [4:0] LAST_PAY = 5'(RES_PAYLOAD_BYTES);
`else
    localparam logic [4:0] LAST_IDX = 5'(RES_PAYLOAD_BYTES - 1);
`endif

    ser_state_t   state;
    fft_result_t  in_rec;
    fft_result_t  head;
    logic [127:0] shifter;
    logic [4:0]   byte_idx;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         xfer;
`ifdef FFT_SER_FRAME_EN
    logic [7:0]   checksum;
`endif

    assign in_rec = '{a_re: i_A_re, a_im: i_A_im, b_re: i_B_re, b_im: i_B_im};
    assign pop    = (state == IDLE) & ~fifo_empty;
    assign xfer   = o_valid & i_ready;
    assign o_busy = ~fifo_empty | (state == SEND);

    fft_res_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (i_res_valid),
        .push_data (in_rec),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_fill)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (i_res_valid & fifo_full & ~pop) begin
            o_overflow <= 1'b1;
        end
    end

    // Serializer: o_data always holds the byte on offer; the shifter holds
    // the bytes still to come, next one in its top byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            shifter  <= '0;
            byte_idx <= '0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
`ifdef FFT_SER_FRAME_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                    if (pop) begin
                        state    <= SEND;
                        byte_idx <= '0;
                        o_valid  <= 1'b1;
`ifdef FFT_SER_FRAME_EN
                        o_data   <= HDR_BYTE;
                        shifter  <= head;
                        checksum <= '0;
`else
                        o_data   <= head[127:120];
                        shifter  <= head << 8;
`endif
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (byte_idx == LAST_IDX) begin
                            state   <= IDLE;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
`ifdef FFT_SER_FRAME_EN
                            // Bytes 1..16 are payload; fold each into the
                            // checksum as it is handed over.
                            if (byte_idx != '0) begin
                                checksum <= checksum ^ o_data;
                            end
                            if (byte_idx == LAST_PAY) begin
                                o_data <= checksum ^ o_data;
                                o_last <= 1'b1;
                            end else begin
                                o_data  <= shifter[127:120];
                                shifter <= shifter << 8;
                            end
`else
                            o_data  <= shifter[127:120];
                            shifter <= shifter << 8;
                            o_last  <= (byte_idx == LAST_IDX - 5'd1);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_result_serializer
// Description : Directed bench for fft_result_serializer. Expected frame
//               bytes are queued when a result is driven and compared as the
//               DUT hands each byte over; stalled bytes must stay stable.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_result_serializer;

`ifdef FFT_SER_FRAME_EN
    localparam int       FB    = 18;
    localparam bit [7:0] FIRST = 8'hA5;
`else
    localparam int       FB    = 16;
    localparam bit [7:0] FIRST = 8'h3F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [31:0] a_re, a_im, b_re, b_im;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        ready;
    logic        o_last;
    logic [2:0]  o_fill;
    logic        o_overflow;
    logic        o_busy;

    int         vectors     = 0;
    int         miscompares = 0;
    int         xfer_cnt    = 0;
    logic [8:0] exp_q[$];
    bit         stalled     = 1'b0;
    logic [9:0] held;

    always #5 clk = ~clk;

    fft_result_serializer #(.DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_res_valid (res_valid),
        .i_A_re      (a_re),
        .i_A_im      (a_im),
        .i_B_re      (b_re),
        .i_B_im      (b_im),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_last      (o_last),
        .o_fill      (o_fill),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive one result pulse; optionally queue the frame it should produce.
    task automatic send_rec(input logic [31:0] ar, ai, br, bi, input bit expect_out);
        logic [127:0] rec;
        logic [7:0]   b;
        logic [7:0]   cks;
        rec = {ar, ai, br, bi};
        cks = 8'h00;
        res_valid = 1'b1;
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        if (expect_out) begin
`ifdef FFT_SER_FRAME_EN
            exp_q.push_back({1'b0, 8'hA5});
`endif
            for (int i = 0; i < 16; i++) begin
                b   = rec[127 - 8*i -: 8];
                cks = cks ^ b;
`ifdef FFT_SER_FRAME_EN
                exp_q.push_back({1'b0, b});
`else
                exp_q.push_back({(i == 15), b});
`endif
            end
`ifdef FFT_SER_FRAME_EN
            exp_q.push_back({1'b1, cks});
`endif
        end
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 2000 && (exp_q.size() != 0 || o_busy); n++) begin
            tick();
        end
        chk(tag, {31'b0, (exp_q.size() == 0 && !o_busy)}, 32'd1);
    endtask

    // Byte monitor: compares every handed-over byte and checks that a
    // stalled byte (and its o_valid/o_last) is held until accepted.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold", {22'b0, o_valid, o_last, o_data}, {22'b0, held});
            end
            if (o_valid && ready) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL spurious_byte: observed %0h expected none", o_data);
                end
                if (exp_q.size() != 0) begin
                    chk("byte", {23'b0, o_last, o_data}, {23'b0, exp_q.pop_front()});
                end
                xfer_cnt++;
                stalled = 1'b0;
            end else if (o_valid) begin
                stalled = 1'b1;
                held    = {o_valid, o_last, o_data};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int n;
        rst = 1'b1; ready = 1'b0; res_valid = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (3) tick();
        chk("rst_data",     {24'b0, o_data}, 32'h0);
        chk("rst_valid",    {31'b0, o_valid}, 32'h0);
        chk("rst_last",     {31'b0, o_last}, 32'h0);
        chk("rst_fill",     {29'b0, o_fill}, 32'h0);
        chk("rst_overflow", {31'b0, o_overflow}, 32'h0);
        chk("rst_busy",     {31'b0, o_busy}, 32'h0);
        rst = 1'b0;
        tick();

        // 1: single record, sink always ready, latency N+2
        ready = 1'b1;
        base  = xfer_cnt;
        send_rec(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000, 1'b1);
        chk("lat_n1_valid", {31'b0, o_valid}, 32'h0);
        tick();
        chk("lat_n2_valid", {31'b0, o_valid}, 32'h1);
        chk("lat_n2_byte0", {24'b0, o_data}, {24'b0, FIRST});
        wait_drain("t1_drain");
        chk("t1_count", xfer_cnt - base, FB);

        // 2: ready pattern 1,0,0,1 repeating
        base = xfer_cnt;
        send_rec(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000, 1'b1);
        for (int k = 0; k < 400 && (exp_q.size() != 0 || o_busy); k++) begin
            ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        chk("t2_drained", {31'b0, (exp_q.size() == 0 && !o_busy)}, 32'd1);
        chk("t2_count", xfer_cnt - base, FB);

        // 3: stalled sink, six results: five kept, sixth dropped
        ready = 1'b0;
        base  = xfer_cnt;
        for (int i = 0; i < 6; i++) begin
            send_rec(32'h11000000 + i, 32'h22000000 + i, 32'h33000000 + i,
                     32'h44000000 + i, (i < 5));
        end
        chk("t3_fill",     {29'b0, o_fill}, 32'd4);
        chk("t3_overflow", {31'b0, o_overflow}, 32'd1);
        chk("t3_valid",    {31'b0, o_valid}, 32'd1);
        ready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_count",     xfer_cnt - base, 5 * FB);
        chk("t3_ovf_stays", {31'b0, o_overflow}, 32'd1);

        // 4: reset after seven transferred bytes
        base = xfer_cnt;
        send_rec(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000, 1'b1);
        send_rec(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h55AA55AA, 1'b1);
        n = 0;
        while (xfer_cnt - base < 7 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_seven", xfer_cnt - base, 32'd7);
        rst = 1'b1; ready = 1'b0;
        exp_q.delete();
        tick();
        chk("t4_valid",    {31'b0, o_valid}, 32'h0);
        chk("t4_fill",     {29'b0, o_fill}, 32'h0);
        chk("t4_overflow", {31'b0, o_overflow}, 32'h0);
        chk("t4_busy",     {31'b0, o_busy}, 32'h0);
        rst = 1'b0; ready = 1'b1;
        tick();
        base = xfer_cnt;
        send_rec(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000, 1'b1);
        wait_drain("t4_drain");
        chk("t4_count", xfer_cnt - base, FB);

        // 5: FIFO full, push lands in the same cycle as a pop
        ready = 1'b0;
        base  = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            send_rec(32'hA0000000 + i, 32'hB0000000 + i, 32'hC0000000 + i,
                     32'hD0000000 + i, 1'b1);
        end
        chk("t5_fill_full", {29'b0, o_fill}, 32'd4);
        ready = 1'b1;
        n = 0;
        while (!(o_valid && o_last) && n < 200) begin
            tick();
            n++;
        end
        chk("t5_last_seen", {31'b0, (o_valid && o_last)}, 32'd1);
        tick();
        chk("t5_gap_valid", {31'b0, o_valid}, 32'h0);
        chk("t5_gap_fill",  {29'b0, o_fill}, 32'd4);
        send_rec(32'hE0000005, 32'hF0000005, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        chk("t5_fill_after", {29'b0, o_fill}, 32'd4);
        chk("t5_overflow",   {31'b0, o_overflow}, 32'h0);
        wait_drain("t5_drain");
        chk("t5_count",     xfer_cnt - base, 6 * FB);
        chk("t5_ovf_final", {31'b0, o_overflow}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
